// File: rtl/gcd_pkg.sv
// gcd_pkg: shared types for the multi-algorithm GCD engine.
//   state_t : handshake/compute FSM states of gcd_multi
//   mode_t  : per-job algorithm select (subtractive Euclid or binary Stein)
package gcd_pkg;

  typedef enum logic [2:0] {
    WAIT_A  = 3'd0,
    IN_A    = 3'd1,
    WAIT_B  = 3'd2,
    IN_B    = 3'd3,
    COMPUTE = 3'd4,
    DONE    = 3'd5
  } state_t;

  typedef enum logic {
    MODE_SUB = 1'b0,
    MODE_BIN = 1'b1
  } mode_t;

endpackage

// File: rtl/gcd_step.sv
// gcd_step: one combinational GCD iteration for either algorithm.
// Ports:
//   i_a, i_b      current operands
//   i_k           binary-mode common power-of-two shift accumulated so far
//   i_mode        algorithm of the running job
//   o_next_a/b/k  operand and shift values after this step
//   o_done        this step terminates the job
//   o_result      GCD, valid only while o_done is high (0 otherwise)
module gcd_step
  import gcd_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int K_W   = $clog2(WIDTH) + 1
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [K_W-1:0]   i_k,
  input  mode_t            i_mode,
  output logic [WIDTH-1:0] o_next_a,
  output logic [WIDTH-1:0] o_next_b,
  output logic [K_W-1:0]   o_next_k,
  output logic             o_done,
  output logic [WIDTH-1:0] o_result
);

  logic             w_a_zero;
  logic             w_b_zero;
  logic             w_a_even;
  logic             w_b_even;
  logic             w_a_eq_b;
  logic             w_a_ge_b;
  logic [WIDTH-1:0] w_a_minus_b;
  logic [WIDTH-1:0] w_b_minus_a;

  assign w_a_zero    = (i_a == {WIDTH{1'b0}});
  assign w_b_zero    = (i_b == {WIDTH{1'b0}});
  assign w_a_even    = ~i_a[0];
  assign w_b_even    = ~i_b[0];
  assign w_a_eq_b    = (i_a == i_b);
  assign w_a_ge_b    = (i_a >= i_b);
  // Only the difference selected by w_a_ge_b is ever used, so neither wraps.
  assign w_a_minus_b = i_a - i_b;
  assign w_b_minus_a = i_b - i_a;

  // Apply the first matching rule of the selected algorithm.
  always_comb begin
    o_next_a = i_a;
    o_next_b = i_b;
    o_next_k = i_k;
    o_done   = 1'b0;
    o_result = {WIDTH{1'b0}};
    case (i_mode)
      MODE_SUB: begin
        if (w_a_zero) begin
          o_done   = 1'b1;
          o_result = i_b;
        end else if (w_b_zero) begin
          o_done   = 1'b1;
          o_result = i_a;
        end else if (w_a_eq_b) begin
          o_done   = 1'b1;
          o_result = i_a;
        end else if (w_a_ge_b) begin
          o_next_a = w_a_minus_b;
        end else begin
          o_next_b = w_b_minus_a;
        end
      end
      MODE_BIN: begin
        // The shifted result never exceeds the smaller nonzero input, so it fits.
        if (w_a_zero) begin
          o_done   = 1'b1;
          o_result = i_b << i_k;
        end else if (w_b_zero) begin
          o_done   = 1'b1;
          o_result = i_a << i_k;
        end else if (w_a_even && w_b_even) begin
          o_next_a = i_a >> 1;
          o_next_b = i_b >> 1;
          o_next_k = i_k + {{(K_W-1){1'b0}}, 1'b1};
        end else if (w_a_even) begin
          o_next_a = i_a >> 1;
        end else if (w_b_even) begin
          o_next_b = i_b >> 1;
        end else if (w_a_ge_b) begin
          // Both odd: the difference is even, so halve it immediately.
          o_next_a = w_a_minus_b >> 1;
        end else begin
          o_next_b = w_b_minus_a >> 1;
        end
      end
      default: begin
        o_next_a = i_a;
        o_next_b = i_b;
        o_next_k = i_k;
        o_done   = 1'b0;
        o_result = {WIDTH{1'b0}};
      end
    endcase
  end

endmodule

// File: rtl/gcd_multi.sv
// gcd_multi: parametrised GCD engine with a four-phase req/ack handshake.
// The host presents A, then B plus the algorithm mode; the result comes back
// on C together with ack, and cycles reports how many compute steps it took.
// Ports:
//   clk     clock, all state updates on the rising edge
//   reset   synchronous active-high reset, aborts any job in progress
//   req     handshake request from host
//   AB      operand bus (A first, then B)
//   mode    0 = subtractive, 1 = binary; captured together with B
//   ack     high while A is being accepted and while the result is valid
//   C       result while in DONE, 0 otherwise
//   busy    high while B is captured and during compute
//   cycles  saturating compute-cycle count of the last job
module gcd_multi
  import gcd_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req,
  input  logic [WIDTH-1:0] AB,
  input  logic             mode,
  output logic             ack,
  output logic [WIDTH-1:0] C,
  output logic             busy,
  output logic [CNT_W-1:0] cycles
);

  localparam int             K_W     = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           r_state;
  state_t           w_next_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [K_W-1:0]   r_k;
  mode_t            r_mode;
  logic [CNT_W-1:0] r_cycles;
  logic             r_ack;
  logic             r_busy;
  logic [WIDTH-1:0] r_c;

  logic [WIDTH-1:0] w_next_a;
  logic [WIDTH-1:0] w_next_b;
  logic [K_W-1:0]   w_next_k;
  logic             w_done;
  logic [WIDTH-1:0] w_result;

  gcd_step #(
    .WIDTH (WIDTH),
    .K_W   (K_W)
  ) u_step (
    .i_a      (r_a),
    .i_b      (r_b),
    .i_k      (r_k),
    .i_mode   (r_mode),
    .o_next_a (w_next_a),
    .o_next_b (w_next_b),
    .o_next_k (w_next_k),
    .o_done   (w_done),
    .o_result (w_result)
  );

  // Next-state logic of the handshake / compute FSM.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      WAIT_A: begin
        if (req) w_next_state = IN_A;
        else     w_next_state = WAIT_A;
      end
      IN_A: begin
        if (!req) w_next_state = WAIT_B;
        else      w_next_state = IN_A;
      end
      WAIT_B: begin
        if (req) w_next_state = IN_B;
        else     w_next_state = WAIT_B;
      end
      IN_B: begin
        w_next_state = COMPUTE;
      end
      COMPUTE: begin
        if (w_done) w_next_state = DONE;
        else        w_next_state = COMPUTE;
      end
      DONE: begin
        if (req) w_next_state = DONE;
        else     w_next_state = WAIT_A;
      end
      default: begin
        w_next_state = WAIT_A;
      end
    endcase
  end

  // State register and operand datapath.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= WAIT_A;
      r_a      <= {WIDTH{1'b0}};
      r_b      <= {WIDTH{1'b0}};
      r_k      <= {K_W{1'b0}};
      r_mode   <= MODE_SUB;
      r_cycles <= {CNT_W{1'b0}};
    end else begin
      r_state <= w_next_state;
      case (r_state)
        IN_A: begin
          // A follows the bus for as long as the host keeps req high.
          r_a <= AB;
        end
        IN_B: begin
          r_b      <= AB;
          r_mode   <= mode_t'(mode);
          r_k      <= {K_W{1'b0}};
          r_cycles <= {CNT_W{1'b0}};
        end
        COMPUTE: begin
          r_a <= w_next_a;
          r_b <= w_next_b;
          r_k <= w_next_k;
          if (r_cycles != CNT_MAX) r_cycles <= r_cycles + CNT_ONE;
          else                     r_cycles <= r_cycles;
        end
        default: begin
          r_a <= r_a;
          r_b <= r_b;
        end
      endcase
    end
  end

  // Outputs are registered from the next state so they line up with r_state.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ack  <= 1'b0;
      r_busy <= 1'b0;
      r_c    <= {WIDTH{1'b0}};
    end else begin
      r_ack  <= (w_next_state == IN_A) || (w_next_state == DONE);
      r_busy <= (w_next_state == IN_B) || (w_next_state == COMPUTE);
      if (w_next_state == DONE) begin
        // Capture on the terminating step, then hold while DONE persists.
        if (r_state == COMPUTE) r_c <= w_result;
        else                    r_c <= r_c;
      end else begin
        r_c <= {WIDTH{1'b0}};
      end
    end
  end

  assign ack    = r_ack;
  assign busy   = r_busy;
  assign C      = r_c;
  assign cycles = r_cycles;

endmodule
